tone_gen: RTL and testbench
===========================

# tone_gen

Four-tone square-wave generator for the piezo buzzer output of the frequency-generator design. It sits directly downstream of the button-to-state decoder and consumes its 2-bit `state` code. The block drives `buzz` at the selected tone's frequency with 50% duty. Tone changes take effect only at a period boundary, so the buzzer never sees a runt pulse.

## Interface
- `CLK_HZ`, default 50_000_000: input clock frequency.
- `F0_HZ`, default 262: tone frequency for state 2'b00.
- `F1_HZ`, default 330: tone frequency for state 2'b01.
- `F2_HZ`, default 392: tone frequency for state 2'b10.
- `F3_HZ`, default 523: tone frequency for state 2'b11.
- `CNT_W`, default 26: half-period counter width. Must hold CLK_HZ/(2*min Fk).
- `clk_50MHz`  in  1: single clock; all logic is on its rising edge.
- `rst`  in  1: asynchronous, active-high reset.
- `state`  in  2: tone select from the state decoder. Sampled every cycle.
- `en`  in  1: tone enable. 0 mutes the output.
- `buzz`  out  1: square-wave buzzer drive.
- `active_tone`  out  2: tone currently being generated.
- `tone_strobe`  out  1: one-cycle pulse when a tone starts or changes.
- `period_cnt`  out  16: completed full periods of the current tone. Present only under the configuration macro.

## Operation
- Half-period constants are computed at elaboration: Nk = CLK_HZ/(2*Fk), using integer truncation. Nk must be >= 1.
- The FSM has three states: IDLE, HIGH and LOW.
- IDLE:
  - `buzz`=0 and the counter is held at 0.
  - When `en`=1: go to HIGH, load `active_tone`<=`state`, pulse `tone_strobe`.
- HIGH and LOW:
  - The counter increments each cycle.
  - At count N(active_tone)-1 the counter returns to 0 and the FSM toggles state (HIGH->LOW or LOW->HIGH).
  - `buzz`=1 in HIGH and 0 in LOW, driven as a registered output.
- Tone change:
  - If `state` != `active_tone` at the LOW->HIGH boundary, load `active_tone`<=`state` and pulse `tone_strobe`.
  - The new half-period count applies from that HIGH phase onward.
  - Changes during a period are never applied mid-period. The value sampled at the boundary cycle wins, and intermediate values are ignored.
- Mute: `en`=0 in HIGH or LOW goes to IDLE on the next edge.
  - `buzz`=0 and the counter is cleared.
  - `active_tone` holds its last value.
- `en` and a state change together in IDLE: the tone loaded is the `state` value on the sampling edge.
- Reset values:
  - FSM=IDLE, counter=0.
  - `buzz`=0, `active_tone`=2'b00, `tone_strobe`=0, `period_cnt`=0.
  - Reset asserted mid-operation aborts immediately, asynchronously.

## Timing
- `en` is sampled high at edge t, so `buzz`=1 and `tone_strobe`=1 are visible after edge t+1.
- HIGH and LOW each last exactly Nk cycles, so the period is 2*Nk cycles.
- Tone-change latency is at most 2*N(old) cycles.
- `tone_strobe` is exactly one cycle wide and is coincident with the first HIGH cycle of the new tone.
- Mute latency is 1 cycle.

## Configuration
- `TONE_GEN_PERIOD_CNT_EN` defined:
  - `period_cnt` increments at each HIGH->LOW->HIGH boundary where the tone is unchanged.
  - It clears to 0 whenever `tone_strobe` fires.
  - It saturates at 16'hFFFF.
- Not defined: the `period_cnt` port and its logic are absent. All other behaviour is identical.

## Test plan
All scenarios use CLK_HZ=1000, F0..F3=250,125,100,50, giving N=2,4,5,10.

- Reset, then `en`=0 for 20 cycles -> `buzz`=0, `active_tone`=0, `tone_strobe` never fires.
- `state`=01, `en` raised -> one `tone_strobe` with `active_tone`=01, then `buzz` runs 4 cycles high, 4 cycles low, repeating.
- While running tone 00, switch `state` to 11 mid-HIGH -> the current period finishes (2H/2L), then the strobe fires and `buzz` runs 10H/10L with no runt pulse.
- `state` toggles 01->10->01 within one period of tone 01 -> no strobe, and the period is unchanged.
- `en` dropped mid-LOW of tone 10 -> next cycle `buzz`=0 and IDLE. Re-enabling restarts with a full 5-cycle HIGH phase.
- With the macro defined: run tone 00 for 5 periods -> `period_cnt`=5. Change tone -> `period_cnt`=0 on the strobe cycle. Assert `rst` mid-HIGH -> all outputs return to their reset values immediately.

Source files
------------

// File: rtl/tone_gen.sv
// Four-tone 50% duty square-wave generator for the piezo buzzer.
// Define TONE_GEN_PERIOD_CNT_EN to add the period_cnt output.
module tone_gen #(
  parameter int CLK_HZ = 50_000_000,
  parameter int F0_HZ  = 262,
  parameter int F1_HZ  = 330,
  parameter int F2_HZ  = 392,
  parameter int F3_HZ  = 523,
  parameter int CNT_W  = 26
) (
  input  logic        clk_50MHz,
  input  logic        rst,
  input  logic [1:0]  state,
  input  logic        en,
  output logic        buzz,
  output logic [1:0]  active_tone,
  output logic        tone_strobe
`ifdef TONE_GEN_PERIOD_CNT_EN
  ,
  output logic [15:0] period_cnt
`endif
);

  localparam logic [CNT_W-1:0] N0 = CNT_W'(CLK_HZ / (2 * F0_HZ));
  localparam logic [CNT_W-1:0] N1 = CNT_W'(CLK_HZ / (2 * F1_HZ));
  localparam logic [CNT_W-1:0] N2 = CNT_W'(CLK_HZ / (2 * F2_HZ));
  localparam logic [CNT_W-1:0] N3 = CNT_W'(CLK_HZ / (2 * F3_HZ));

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_HIGH = 2'd1,
    S_LOW  = 2'd2
  } fsm_t;

  fsm_t             r_fsm, w_fsm_next;
  logic [CNT_W-1:0] r_cnt, w_cnt_next;
  logic [1:0]       r_tone, w_tone_next;
  logic             r_load, w_load;
  logic [CNT_W-1:0] w_half;
  logic             w_last;

  // Output stage: buzz, strobe and tone are registered one cycle after the FSM
  logic             r_buzz;
  logic             r_strobe;
  logic [1:0]       r_tone_out;

  always_comb begin
    case (r_tone)
      2'd0:    w_half = N0;
      2'd1:    w_half = N1;
      2'd2:    w_half = N2;
      default: w_half = N3;
    endcase
  end

  assign w_last = (r_cnt == w_half - CNT_W'(1));

`ifdef TONE_GEN_PERIOD_CNT_EN
  logic        w_wrap;
  logic        r_wrap;
  logic [15:0] r_pcnt;
`endif

  always_comb begin
    w_fsm_next  = r_fsm;
    w_cnt_next  = r_cnt;
    w_tone_next = r_tone;
    w_load      = 1'b0;
`ifdef TONE_GEN_PERIOD_CNT_EN
    w_wrap      = 1'b0;
`endif
    case (r_fsm)
      S_IDLE: begin
        w_cnt_next = '0;
        if (en) begin
          w_fsm_next  = S_HIGH;
          w_tone_next = state;
          w_load      = 1'b1;
        end
      end
      S_HIGH: begin
        if (!en) begin
          w_fsm_next = S_IDLE;
          w_cnt_next = '0;
        end else if (w_last) begin
          w_fsm_next = S_LOW;
          w_cnt_next = '0;
        end else begin
          w_cnt_next = r_cnt + CNT_W'(1);
        end
      end
      S_LOW: begin
        if (!en) begin
          w_fsm_next = S_IDLE;
          w_cnt_next = '0;
        end else if (w_last) begin
          // Period boundary: the only point where a new tone may be taken
          w_fsm_next = S_HIGH;
          w_cnt_next = '0;
          if (state != r_tone) begin
            w_tone_next = state;
            w_load      = 1'b1;
          end else begin
`ifdef TONE_GEN_PERIOD_CNT_EN
            w_wrap = 1'b1;
`endif
          end
        end else begin
          w_cnt_next = r_cnt + CNT_W'(1);
        end
      end
      default: begin
        w_fsm_next = S_IDLE;
        w_cnt_next = '0;
      end
    endcase
  end

  always_ff @(posedge clk_50MHz or posedge rst) begin
    if (rst) begin
      r_fsm      <= S_IDLE;
      r_cnt      <= '0;
      r_tone     <= 2'b00;
      r_load     <= 1'b0;
      r_buzz     <= 1'b0;
      r_strobe   <= 1'b0;
      r_tone_out <= 2'b00;
    end else begin
      r_fsm      <= w_fsm_next;
      r_cnt      <= w_cnt_next;
      r_tone     <= w_tone_next;
      r_load     <= w_load;
      r_buzz     <= (r_fsm == S_HIGH);
      r_strobe   <= r_load;
      r_tone_out <= r_tone;
    end
  end

`ifdef TONE_GEN_PERIOD_CNT_EN
  always_ff @(posedge clk_50MHz or posedge rst) begin
    if (rst) begin
      r_wrap <= 1'b0;
      r_pcnt <= 16'h0000;
    end else begin
      r_wrap <= w_wrap;
      if (r_load)
        r_pcnt <= 16'h0000;
      else if (r_wrap && (r_pcnt != 16'hFFFF))
        r_pcnt <= r_pcnt + 16'h0001;
    end
  end

  assign period_cnt = r_pcnt;
`endif

  assign buzz        = r_buzz;
  assign tone_strobe = r_strobe;
  assign active_tone = r_tone_out;

endmodule

// File: tb/tb_tone_gen.sv
// Self-checking bench for tone_gen: per-cycle expected buzz/strobe/tone
// values are queued with the stimulus and compared as the DUT produces them.
module tb_tone_gen;

  logic       clk;
  logic       rst;
  logic [1:0] state;
  logic       en;
  logic       buzz;
  logic [1:0] active_tone;
  logic       tone_strobe;
`ifdef TONE_GEN_PERIOD_CNT_EN
  logic [15:0] period_cnt;
`endif

  typedef struct packed {
    logic       b;
    logic       s;
    logic [1:0] t;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp;
  int   n_err;
  logic [1:0] last_tone;

  tone_gen #(
    .CLK_HZ(1000),
    .F0_HZ (250),
    .F1_HZ (125),
    .F2_HZ (100),
    .F3_HZ (50),
    .CNT_W (8)
  ) dut (
    .clk_50MHz  (clk),
    .rst        (rst),
    .state      (state),
    .en         (en),
    .buzz       (buzz),
    .active_tone(active_tone),
    .tone_strobe(tone_strobe)
`ifdef TONE_GEN_PERIOD_CNT_EN
    ,
    .period_cnt (period_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic push(input logic b, input logic s, input logic [1:0] t);
    exp_t e;
    e.b = b;
    e.s = s;
    e.t = t;
    exp_q.push_back(e);
  endtask

  // One full tone period: n high cycles (first one optionally strobed), n low
  task automatic push_period(input logic [1:0] t, input int n, input logic strobe);
    for (int i = 0; i < n; i++) push(1'b1, strobe && (i == 0), t);
    for (int i = 0; i < n; i++) push(1'b0, 1'b0, t);
  endtask

  task automatic go_idle();
    en = 1'b0;
    repeat (3) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset();
    exp_t e;
    int   cyc;
    rst   = 1'b1;
    en    = 1'b0;
    state = 2'b00;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if ({buzz, tone_strobe, active_tone} !== 4'b0000) begin
      n_err++;
      $display("FAIL reset_state: got b=%b s=%b t=%0d, expected b=0 s=0 t=0",
               buzz, tone_strobe, active_tone);
    end
`ifdef TONE_GEN_PERIOD_CNT_EN
    n_cmp++;
    if (period_cnt !== 16'h0000) begin
      n_err++;
      $display("FAIL reset_pcnt: got %0d, expected 0", period_cnt);
    end
`endif
    rst   = 1'b0;
    state = 2'b11;
    for (int i = 0; i < 20; i++) push(1'b0, 1'b0, 2'b00);
    cyc = 0;
    while (exp_q.size() > 0) begin
      @(posedge clk);
      #1;
      e = exp_q.pop_front();
      n_cmp++;
      if ({buzz, tone_strobe, active_tone} !== e) begin
        n_err++;
        $display("FAIL idle_muted obs%0d: got b=%b s=%b t=%0d, expected b=%b s=%b t=%0d",
                 cyc, buzz, tone_strobe, active_tone, e.b, e.s, e.t);
      end
      cyc++;
    end
    last_tone = 2'b00;
    $display("test_reset: %0d idle cycles checked", cyc);
  endtask

  task automatic test_tone01();
    exp_t e;
    int   cyc;
    go_idle();
    state = 2'b01;
    en    = 1'b1;
    push(1'b0, 1'b0, last_tone);
    push_period(2'b01, 4, 1'b1);
    push_period(2'b01, 4, 1'b0);
    push_period(2'b01, 4, 1'b0);
    cyc = 0;
    while (exp_q.size() > 0) begin
      @(posedge clk);
      #1;
      e = exp_q.pop_front();
      n_cmp++;
      if ({buzz, tone_strobe, active_tone} !== e) begin
        n_err++;
        $display("FAIL tone01 obs%0d: got b=%b s=%b t=%0d, expected b=%b s=%b t=%0d",
                 cyc, buzz, tone_strobe, active_tone, e.b, e.s, e.t);
      end
      cyc++;
    end
    last_tone = 2'b01;
    $display("test_tone01: %0d cycles checked", cyc);
  endtask

  task automatic test_tone_change();
    exp_t e;
    int   cyc;
    go_idle();
    state = 2'b00;
    en    = 1'b1;
    push(1'b0, 1'b0, last_tone);
    push_period(2'b00, 2, 1'b1);
    push_period(2'b00, 2, 1'b0);
    push_period(2'b11, 10, 1'b1);
    push_period(2'b11, 10, 1'b0);
    cyc = 0;
    while (exp_q.size() > 0) begin
      @(posedge clk);
      #1;
      e = exp_q.pop_front();
      n_cmp++;
      if ({buzz, tone_strobe, active_tone} !== e) begin
        n_err++;
        $display("FAIL tone_change obs%0d: got b=%b s=%b t=%0d, expected b=%b s=%b t=%0d",
                 cyc, buzz, tone_strobe, active_tone, e.b, e.s, e.t);
      end
      if (cyc == 4) state = 2'b11;
      cyc++;
    end
    last_tone = 2'b11;
    $display("test_tone_change: %0d cycles checked", cyc);
  endtask

  task automatic test_glitch();
    exp_t e;
    int   cyc;
    go_idle();
    state = 2'b01;
    en    = 1'b1;
    push(1'b0, 1'b0, last_tone);
    push_period(2'b01, 4, 1'b1);
    push_period(2'b01, 4, 1'b0);
    push_period(2'b01, 4, 1'b0);
    cyc = 0;
    while (exp_q.size() > 0) begin
      @(posedge clk);
      #1;
      e = exp_q.pop_front();
      n_cmp++;
      if ({buzz, tone_strobe, active_tone} !== e) begin
        n_err++;
        $display("FAIL glitch obs%0d: got b=%b s=%b t=%0d, expected b=%b s=%b t=%0d",
                 cyc, buzz, tone_strobe, active_tone, e.b, e.s, e.t);
      end
      if (cyc == 2) state = 2'b10;
      if (cyc == 5) state = 2'b01;
      cyc++;
    end
    last_tone = 2'b01;
    $display("test_glitch: %0d cycles checked", cyc);
  endtask

  task automatic test_mute();
    exp_t e;
    int   cyc;
    go_idle();
    state = 2'b10;
    en    = 1'b1;
    push(1'b0, 1'b0, last_tone);
    push_period(2'b10, 5, 1'b1);
    push(1'b0, 1'b0, 2'b10);
    push_period(2'b10, 5, 1'b1);
    push_period(2'b10, 5, 1'b0);
    cyc = 0;
    while (exp_q.size() > 0) begin
      @(posedge clk);
      #1;
      e = exp_q.pop_front();
      n_cmp++;
      if ({buzz, tone_strobe, active_tone} !== e) begin
        n_err++;
        $display("FAIL mute obs%0d: got b=%b s=%b t=%0d, expected b=%b s=%b t=%0d",
                 cyc, buzz, tone_strobe, active_tone, e.b, e.s, e.t);
      end
      if (cyc == 7)  en = 1'b0;
      if (cyc == 10) en = 1'b1;
      cyc++;
    end
    last_tone = 2'b10;
    $display("test_mute: %0d cycles checked", cyc);
  endtask

  task automatic test_period_reset();
    exp_t e;
    int   cyc;
    go_idle();
    state = 2'b00;
    en    = 1'b1;
    push(1'b0, 1'b0, last_tone);
    for (int p = 0; p < 6; p++) push_period(2'b00, 2, p == 0);
    push(1'b1, 1'b1, 2'b01);
    push(1'b1, 1'b0, 2'b01);
    cyc = 0;
    while (exp_q.size() > 0) begin
      @(posedge clk);
      #1;
      e = exp_q.pop_front();
      n_cmp++;
      if ({buzz, tone_strobe, active_tone} !== e) begin
        n_err++;
        $display("FAIL period_run obs%0d: got b=%b s=%b t=%0d, expected b=%b s=%b t=%0d",
                 cyc, buzz, tone_strobe, active_tone, e.b, e.s, e.t);
      end
`ifdef TONE_GEN_PERIOD_CNT_EN
      if (cyc == 1 || cyc == 5 || cyc == 24 || cyc == 25) begin
        n_cmp++;
        if (period_cnt !== ((cyc == 5) ? 16'd1 : (cyc == 24) ? 16'd5 : 16'd0)) begin
          n_err++;
          $display("FAIL period_cnt obs%0d: got %0d, expected %0d", cyc, period_cnt,
                   (cyc == 5) ? 1 : (cyc == 24) ? 5 : 0);
        end
      end
`endif
      if (cyc == 22) state = 2'b01;
      cyc++;
    end
    // Mid-HIGH of tone 01: reset must clear outputs without waiting for an edge
    rst = 1'b1;
    #1;
    n_cmp++;
    if ({buzz, tone_strobe, active_tone} !== 4'b0000) begin
      n_err++;
      $display("FAIL async_reset: got b=%b s=%b t=%0d, expected b=0 s=0 t=0",
               buzz, tone_strobe, active_tone);
    end
`ifdef TONE_GEN_PERIOD_CNT_EN
    n_cmp++;
    if (period_cnt !== 16'h0000) begin
      n_err++;
      $display("FAIL async_reset_pcnt: got %0d, expected 0", period_cnt);
    end
`endif
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if ({buzz, tone_strobe, active_tone} !== 4'b0000) begin
      n_err++;
      $display("FAIL reset_held: got b=%b s=%b t=%0d, expected b=0 s=0 t=0",
               buzz, tone_strobe, active_tone);
    end
    rst = 1'b0;
    last_tone = 2'b00;
    $display("test_period_reset: %0d cycles checked plus async reset", cyc);
  endtask

  initial begin
    n_cmp     = 0;
    n_err     = 0;
    rst       = 1'b1;
    en        = 1'b0;
    state     = 2'b00;
    last_tone = 2'b00;
    test_reset();
    test_tone01();
    test_tone_change();
    test_glitch();
    test_mute();
    test_period_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
